// File: rtl/shift_right_sequencer_pkg.sv
// Shared encodings and width constants for the right-shift sequencer and its
// single-position shift stage.
package shift_right_sequencer_pkg;

  localparam int WIDTH = 8;
  localparam int AMT_W = 3;

  typedef enum logic [1:0] {
    SRS_LOGIC = 2'b00,
    SRS_ROT   = 2'b01,
    SRS_CARRY = 2'b10,
    SRS_ARITH = 2'b11
  } srs_mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    FINISH = 2'b10
  } srs_state_e;

endpackage

// File: rtl/shift_right_sequencer_step.sv
// sru_step: combinational one-position right shift; the fill bit entering
// bit7 is chosen by mode, and the old bit0 is reported as the shifted-out bit.
module sru_step #(
  parameter int WIDTH = shift_right_sequencer_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic [1:0]       mode_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] value_o,
  output logic             out_o
);
  import shift_right_sequencer_pkg::*;

  logic fill;

  always_comb begin
    fill = 1'b0;
    case (srs_mode_e'(mode_i))
      SRS_LOGIC: fill = 1'b0;
      SRS_ROT:   fill = value_i[0];
      SRS_CARRY: fill = cin_i;
      SRS_ARITH: fill = value_i[WIDTH-1];
      default:   fill = 1'b0;
    endcase
  end

  assign value_o = {fill, value_i[WIDTH-1:1]};
  assign out_o   = value_i[0];

endmodule

// File: rtl/shift_right_sequencer.sv
// Multi-cycle right-shift controller: iterates sru_step 'amount' times.
// Optional SRS_ZERO_FLAG_EN adds a registered 'zero' flag held with result.
module shift_right_sequencer #(
  parameter int WIDTH = shift_right_sequencer_pkg::WIDTH,
  parameter int AMT_W = shift_right_sequencer_pkg::AMT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [AMT_W-1:0] amount,
  input  logic [1:0]       mode,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef SRS_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);
  import shift_right_sequencer_pkg::*;

  srs_state_e       state_q;
  logic [WIDTH-1:0] work_q;
  logic [AMT_W-1:0] cnt_q;
  logic [1:0]       mode_q;
  logic             cin_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;

  logic [WIDTH-1:0] step_d;
  logic             step_out_d;

  sru_step #(.WIDTH(WIDTH)) u_step (
    .value_i (work_q),
    .mode_i  (mode_q),
    .cin_i   (cin_q),
    .value_o (step_d),
    .out_o   (step_out_d)
  );

  // Result/cout are loaded on the edge entering FINISH so they are visible
  // in the same cycle as the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      work_q   <= '0;
      cnt_q    <= '0;
      mode_q   <= '0;
      cin_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            work_q <= x;
            cnt_q  <= amount;
            mode_q <= mode;
            cin_q  <= cin;
            if (amount == '0) begin
              state_q  <= FINISH;
              done_q   <= 1'b1;
              result_q <= x;
              cout_q   <= 1'b0;
            end else begin
              state_q <= SHIFT;
              busy_q  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          work_q <= step_d;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == AMT_W'(1)) begin
            state_q  <= FINISH;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= step_d;
            cout_q   <= step_out_d;
          end
        end
        FINISH: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SRS_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
    end else if (state_q == IDLE && start && amount == '0) begin
      zero_q <= (x == '0);
    end else if (state_q == SHIFT && cnt_q == AMT_W'(1)) begin
      zero_q <= (step_d == '0);
    end
  end

  assign zero = zero_q;
`endif

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_shift_right_sequencer.sv
// Randomised + directed bench for shift_right_sequencer; reference model is a
// cycle-countdown timeline with results computed by plain shift arithmetic.
module tb_shift_right_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, cin;
  logic [7:0] x;
  logic [2:0] amount;
  logic [1:0] mode;
  logic       busy, done, cout;
  logic [7:0] result;
`ifdef SRS_ZERO_FLAG_EN
  logic       zero;
`endif

  int checks   = 0;
  int failures = 0;

  shift_right_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .x      (x),
    .amount (amount),
    .mode   (mode),
    .cin    (cin),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
`ifdef SRS_ZERO_FLAG_EN
    ,
    .zero   (zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Closed-form result of an a-position shift; returns {cout, result}.
  function automatic logic [8:0] ref_op(input logic [7:0] v, input int a,
                                        input logic [1:0] m, input logic c);
    logic [7:0]        r;
    logic [7:0]        ones;
    logic [15:0]       d;
    logic signed [7:0] s;
    logic              co;
    ones = 8'hFF;
    r    = 8'h00;
    case (m)
      2'b00: r = v >> a;
      2'b01: begin d = {v, v} >> a; r = d[7:0]; end
      2'b10: r = (v >> a) | (c ? ~(ones >> a) : 8'h00);
      default: begin s = v; r = s >>> a; end
    endcase
    co = (a == 0) ? 1'b0 : v[a-1];
    return {co, r};
  endfunction

  // Model: m_left counts cycles until (and including) the done cycle.
  int         m_left  = 0;
  logic [7:0] m_res   = 8'h00, m_pend = 8'h00;
  logic       m_cout  = 1'b0, m_pcout = 1'b0;
  logic       m_zero  = 1'b0;
  bit         chk_en  = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_res = 8'h00; m_cout = 1'b0; m_zero = 1'b0;
    end else if (m_left == 0) begin
      if (start) begin
        {m_pcout, m_pend} = ref_op(x, int'(amount), mode, cin);
        m_left = int'(amount) + 1;
      end
    end else begin
      m_left--;
    end
    if (!rst && m_left == 1) begin
      m_res = m_pend; m_cout = m_pcout; m_zero = (m_pend == 8'h00);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",   16'(busy),   16'(m_left > 1));
      chk("done",   16'(done),   16'(m_left == 1));
      chk("result", 16'(result), 16'(m_res));
      chk("cout",   16'(cout),   16'(m_cout));
`ifdef SRS_ZERO_FLAG_EN
      chk("zero",   16'(zero),   16'(m_zero));
`endif
    end
  end

  task automatic do_op(input string nm, input logic [7:0] xv, input logic [2:0] a,
                       input logic [1:0] md, input logic c,
                       input logic [7:0] er, input logic ec);
    int lat, bcnt;
    bit seen;
    @(negedge clk);
    x = xv; amount = a; mode = md; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0; x = 8'($urandom); amount = 3'($urandom); mode = 2'($urandom); cin = 1'($urandom);
    lat = 0; bcnt = 0; seen = 0;
    while (!seen && lat < 20) begin
      lat++;
      if (done) seen = 1;
      else begin
        if (busy) bcnt++;
        @(negedge clk);
      end
    end
    chki({nm, "_done_seen"}, int'(seen), 1);
    chki({nm, "_latency"}, lat, int'(a) + 1);
    chki({nm, "_busy_cycles"}, bcnt, int'(a));
    chk({nm, "_result"}, 16'(result), 16'(er));
    chk({nm, "_cout"}, 16'(cout), 16'(ec));
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, second, ndone;
    rst = 1'b1; start = 1'b0; x = 8'h00; amount = 3'd0; mode = 2'b00; cin = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 16'(busy), 16'h0);
    chk("reset_done", 16'(done), 16'h0);
    chk("reset_result", 16'(result), 16'h0);
    chk("reset_cout", 16'(cout), 16'h0);
    rst = 1'b0;
    chk_en = 1;

    // pin the reference model to hand-derived values
    chk("pin_logic", 16'(ref_op(8'hB6, 3, 2'b00, 1'b0)), 16'(9'h116));
    chk("pin_rot",   16'(ref_op(8'h81, 1, 2'b01, 1'b0)), 16'(9'h1C0));
    chk("pin_arith", 16'(ref_op(8'h90, 4, 2'b11, 1'b0)), 16'(9'h0F9));
    chk("pin_carry", 16'(ref_op(8'h0F, 2, 2'b10, 1'b1)), 16'(9'h1C3));

    do_op("logic", 8'hB6, 3'd3, 2'b00, 1'b0, 8'h16, 1'b1);
    do_op("rot",   8'h81, 3'd1, 2'b01, 1'b0, 8'hC0, 1'b1);
    do_op("arith", 8'h90, 3'd4, 2'b11, 1'b0, 8'hF9, 1'b0);
    do_op("carry1", 8'h0F, 3'd2, 2'b10, 1'b1, 8'hC3, 1'b1);
    do_op("carry0", 8'h0F, 3'd2, 2'b10, 1'b0, 8'h03, 1'b1);
    do_op("amt0",  8'h5A, 3'd0, 2'b01, 1'b1, 8'h5A, 1'b0);
    do_op("rot7",  8'h01, 3'd7, 2'b01, 1'b0, 8'h02, 1'b0);
`ifdef SRS_ZERO_FLAG_EN
    do_op("zero", 8'h01, 3'd1, 2'b00, 1'b0, 8'h00, 1'b1);
    chk("zero_flag", 16'(zero), 16'h1);
`endif

    // start while busy is ignored: one done, first operand's result
    @(negedge clk);
    x = 8'hA5; amount = 3'd7; mode = 2'b00; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); x = 8'hFF; amount = 3'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("busy_start_result", 16'(result), 16'h0001);
      end
    end
    chki("busy_start_done_count", ndone, 1);

    // start held high: accepts every amount+2 cycles
    @(negedge clk);
    x = 8'h3C; amount = 3'd2; mode = 2'b00; start = 1'b1;
    first = -1; second = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    start = 1'b0;
    chki("b2b_second_seen", int'(second >= 0), 1);
    chki("b2b_spacing", second - first, 4);
    repeat (6) @(negedge clk);

    // reset mid-operation abandons the shift
    x = 8'hC3; amount = 3'd6; mode = 2'b11; start = 1'b1;
    @(negedge clk); start = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("midrst_busy", 16'(busy), 16'h0);
    chk("midrst_result", 16'(result), 16'h0);
    chk("midrst_done", 16'(done), 16'h0);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chki("midrst_no_done", ndone, 0);
    do_op("after_rst", 8'hC3, 3'd6, 2'b11, 1'b0, 8'hFF, 1'b0);

    // randomised traffic, occasional resets, model checks every cycle
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start  = ($urandom_range(0, 2) == 0);
      x      = 8'($urandom);
      amount = 3'($urandom);
      mode   = 2'($urandom);
      cin    = 1'($urandom);
      rst    = ($urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (12) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_right_sequencer.md
Name: shift_right_sequencer

Overview:
- Multi-cycle controller that drives an 8-bit, 1-position right-shift stage for `amount` iterations.
- Together they implement variable-distance right shifts of 0 to 7 positions: logical, rotate, shift-through-carry and arithmetic.
- Sits between the ALU issue logic (start/done handshake) and the shift datapath.
- Exposes the final result and the last bit shifted out.

Parameters:
- WIDTH, 8, operand/result width; only 8 is supported.
- AMT_W, 3, width of the shift-amount field, i.e. log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock, single domain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new shift; sampled only in IDLE.
- x  input  WIDTH  operand; captured when start is accepted.
- amount  input  AMT_W  shift distance 0..7; captured with x.
- mode  input  2  mode select; captured with x.
  - 00: logical, msb fill 0.
  - 01: rotate, msb fill is the old bit0.
  - 10: through-carry, msb fill is cin.
  - 11: arithmetic, msb fill is the old bit7.
- cin  input  1  fill bit for mode 10; captured with x.
- busy  output  1  high while an operation is in progress (SHIFT state).
- done  output  1  one-cycle pulse when the result is valid.
- result  output  WIDTH  shifted value; held until the next accepted start.
- cout  output  1  last bit shifted out of bit0; held with result.

Behaviour:
Reset:
- State goes to IDLE.
- busy=0, done=0, result=8'h00, cout=0.
- Counter and captured fields are cleared.
- Reset overrides all other inputs in the same cycle, including a reset asserted mid-operation: the operation is abandoned and no done pulse is issued.

States:
- IDLE:
  - On start=1, load the working register with x, count with amount, and capture mode and cin.
  - If amount=0, go to FINISH; otherwise go to SHIFT.
- SHIFT:
  - Each cycle, the working register takes the stage output: {fill, reg[7:1]}. cout_reg takes reg[0]. count decrements.
  - When count reaches 1 (this is the final shift), go to FINISH.
- FINISH:
  - done=1 for exactly one cycle.
  - result and cout are updated from the working registers in this cycle.
  - Go to IDLE.

Timing:
- Start sampled at edge T.
- busy=1 during cycles T+1..T+amount.
- done=1 in cycle T+amount+1.
- Total latency amount+1 cycles; start-to-start minimum is amount+2 cycles.

Fill and carry:
- Fill is taken from the value before each step. In rotate mode, bit0 therefore moves to bit7.
- In arithmetic mode, bit7 is replicated.
- With amount=0: result=x and cout=0.

Start handling:
- start in SHIFT or FINISH is ignored; it is not queued.
- start in IDLE in the cycle after FINISH is accepted normally.
- x, amount, mode and cin may change freely after capture without effect.

Outputs between operations:
- result and cout are stable from FINISH until the next FINISH, or until reset.

Optional Feature:
- Macro: SRS_ZERO_FLAG_EN.
- When defined:
  - Adds output port `zero` (1 bit).
  - zero is registered alongside result: 1 when the final result is 8'h00.
  - Reset value 0; it is held with result.
- When undefined:
  - The port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - Mode encodings: SRS_LOGIC=2'b00, SRS_ROT=2'b01, SRS_CARRY=2'b10, SRS_ARITH=2'b11.
  - State encodings: IDLE=2'b00, SHIFT=2'b01, FINISH=2'b10.
  - Width constants: WIDTH, AMT_W.
- One sub-module, sru_step: a combinational single-position right shift.
  - Inputs: value, mode, cin.
  - Outputs: shifted value and the bit shifted out.
  - Instantiated once; the sequencer owns all state.

Test Plan:
- Logical shift: x=8'hB6, amount=3, mode=00 -> done at T+4, result=8'h16, cout=1; busy high for exactly 3 cycles.
- Rotate: x=8'h81, amount=1, mode=01 -> result=8'hC0, cout=1. Arithmetic: x=8'h90, amount=4, mode=11 -> result=8'hF9, cout=0.
- Through-carry: x=8'h0F, cin=1, amount=2, mode=10 -> result=8'hC3, cout=1. Repeat with cin=0 -> result=8'h03.
- Zero amount: x=8'h5A, amount=0 -> done at T+1, result=8'h5A, cout=0, busy never asserted. With SRS_ZERO_FLAG_EN: x=8'h01, amount=1, mode=00 -> zero=1.
- Start while busy: start at T (amount=7); second start with x=8'hFF at T+3 is ignored -> single done at T+8 carrying the first result.
- Back-to-back: start held high continuously -> operations accepted at T and T+amount+2.
- Reset mid-operation: rst at T+2 -> busy=0, result=8'h00, no done pulse; a fresh start afterwards completes correctly.
